// File: rtl/rr_sel_sequencer.sv
// Round-robin select generator for a 4-input mux: registered sel/one-hot gnt,
// grant held until ack or watchdog expiry, back-to-back grants on release.
//
// state | meaning
// IDLE  | no grant outstanding, valid=0, arbitrate on any req
// GRANT | sel/gnt frozen and valid=1 until ack or watchdog release
module rr_sel_sequencer #(
    parameter int TIMEOUT = 16,
    parameter int CNTW    = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       ack,
    output logic [1:0] sel,
    output logic [3:0] gnt,
    output logic       valid,
    output logic       timeout
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(TIMEOUT - 1);
    localparam logic [CNTW-1:0] CNT_MAX  = '1;
    localparam logic            WDOG_EN  = (TIMEOUT != 0);

    state_t          state_q, state_d;
    logic [1:0]      ptr_q, ptr_d;
    logic [1:0]      sel_q, sel_d;
    logic [3:0]      gnt_q, gnt_d;
    logic            valid_q, valid_d;
    logic            timeout_q, timeout_d;
    logic [CNTW-1:0] cnt_q, cnt_d;

    logic [1:0]      arb_base;
    logic [1:0]      win_idx;
    logic            win_found;
    logic            expire;
    logic            release_now;

    // On release the new pointer is sel+1, so arbitrate from there in the same cycle.
    assign arb_base    = (state_q == GRANT) ? 2'(sel_q + 2'd1) : ptr_q;
    assign expire      = WDOG_EN && (cnt_q == CNT_LAST);
    assign release_now = ack || expire;

    always_comb begin
        logic [1:0] idx;
        win_found = 1'b0;
        win_idx   = 2'd0;
        idx       = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            idx = 2'(arb_base + 2'(i));
            if (req[idx]) begin
                win_found = 1'b1;
                win_idx   = idx;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        sel_d     = sel_q;
        gnt_d     = gnt_q;
        valid_d   = valid_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                gnt_d   = 4'b0000;
                if (win_found) begin
                    sel_d   = win_idx;
                    gnt_d   = 4'b0001 << win_idx;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (release_now) begin
                    ptr_d     = 2'(sel_q + 2'd1);
                    timeout_d = ~ack;
                    cnt_d     = '0;
                    if (win_found) begin
                        sel_d = win_idx;
                        gnt_d = 4'b0001 << win_idx;
                    end else begin
                        valid_d = 1'b0;
                        gnt_d   = 4'b0000;
                        state_d = IDLE;
                    end
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                gnt_d   = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= 2'd0;
            sel_q     <= 2'd0;
            gnt_q     <= 4'b0000;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            sel_q     <= sel_d;
            gnt_q     <= gnt_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
        end
    end

    assign sel     = sel_q;
    assign gnt     = gnt_q;
    assign valid   = valid_q;
    assign timeout = timeout_q;

endmodule
